// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the
// cycles-per-bit helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,  // only reachable when UART_TX_PARITY_EN is defined
    STOP
  } tx_state_t;

  localparam int DATA_BITS = 8;

  // Clock cycles per serial bit (integer division, truncating).
  function automatic int bit_clk(input int clk_hz, input int bps);
    return clk_hz / bps;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-wide valid/ready handshake between a producer (master) and the UART
// transmitter (slave).
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BIT_CLK-1 and flags the terminal count for
// one cycle. Holding clear keeps it parked at 0 so the first bit of a frame
// always gets a full period.
module uart_baud_gen #(
  parameter int BIT_CLK = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (BIT_CLK > 1) ? $clog2(BIT_CLK) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(BIT_CLK - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Free-running bit counter, wrapping on terminal count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_reg <= '0;
    end else if (cnt_reg == TERM) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = !clear && (cnt_reg == TERM);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input and registered serial
// output. Defining UART_TX_PARITY_EN inserts an even-parity bit between the
// data bits and the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ      = 66_000_000,
  parameter int BITRATE_BPS = 9_600
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus,
  output logic       tx,
  output logic       busy
);

  localparam int BIT_CLK = bit_clk(CLK_HZ, BITRATE_BPS);

  if (BIT_CLK < 2) begin : g_bit_clk_check
    $error("uart_tx: BIT_CLK = CLK_HZ/BITRATE_BPS must be at least 2");
  end

  tx_state_t            state_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [2:0]           bit_idx_reg;
  logic                 tx_reg;
  logic                 busy_reg;
  logic                 ready_reg;
`ifdef UART_TX_PARITY_EN
  logic                 parity_reg;
`endif
  logic                 baud_tick;
  logic                 baud_clear;

  // The bit timer only runs while a frame is on the line.
  assign baud_clear = (state_reg == IDLE);

  uart_baud_gen #(
    .BIT_CLK(BIT_CLK)
  ) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .clear(baud_clear),
    .tick (baud_tick)
  );

  // Frame sequencer; every output is registered so the line is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      ready_reg   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          bit_idx_reg <= '0;
          if (bus.tx_valid && ready_reg) begin
            shift_reg  <= bus.tx_data;
            state_reg  <= START;
            tx_reg     <= 1'b0;
            busy_reg   <= 1'b1;
            ready_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= ^bus.tx_data;
`endif
          end
        end
        START: begin
          if (baud_tick) begin
            state_reg   <= DATA;
            tx_reg      <= shift_reg[0];
            bit_idx_reg <= '0;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_idx_reg == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_reg <= PARITY;
              tx_reg    <= parity_reg;
`else
              state_reg <= STOP;
              tx_reg    <= 1'b1;
`endif
            end else begin
              shift_reg   <= shift_reg >> 1;
              tx_reg      <= shift_reg[1];
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end
        end
        PARITY: begin
`ifdef UART_TX_PARITY_EN
          if (baud_tick) begin
            state_reg <= STOP;
            tx_reg    <= 1'b1;
          end
`else
          // Unreachable without the parity option; recover to idle.
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b1;
`endif
        end
        STOP: begin
          if (baud_tick) begin
            state_reg <= IDLE;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign tx           = tx_reg;
  assign busy         = busy_reg;
  assign bus.tx_ready = ready_reg;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter: serialises one byte per frame onto `tx` at a fixed bitrate.
- Frame order: start bit (0), 8 data bits LSB first, stop bit (1).
- Pairs with the team's UART receiver to form the full serial link.
- Byte-wide valid/ready handshake on the parallel side; the serial line idles high.

Parameters:
- CLK_HZ, 66_000_000, system clock frequency in Hz (integer).
- BITRATE_BPS, 9_600, line bitrate in bits/s (integer).
- BIT_CLK, CLK_HZ/BITRATE_BPS (integer division, truncating), clock cycles per bit.
  - Derived; not overridden.
  - Elaboration error if BIT_CLK < 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to transmit; sampled on handshake.
- tx_valid  input  1  producer has a byte.
- tx_ready  output  1  block can accept a byte.
- tx  output  1  serial line.
- busy  output  1  frame in progress.

Behaviour:
- Reset (rst=1 at a clk edge) takes effect at that edge, from any state:
  - state=IDLE, tx=1, tx_ready=1, busy=0, counters=0.
  - Reset mid-frame aborts the frame immediately; the line returns high on the next cycle.
  - No partial byte is resumed.
- Handshake:
  - Transfer occurs when tx_valid && tx_ready at a clk edge; tx_data is latched into an internal shift register.
  - tx_ready=1 only in IDLE. tx_data may change freely after the transfer edge.
  - tx_valid without tx_ready: the byte is held by the producer; nothing is dropped.
- States, all registered outputs:
  - IDLE: tx=1, busy=0. On transfer go to START. Counters cleared.
  - START: tx=0 for exactly BIT_CLK cycles, then go to DATA with bit index=0.
  - DATA: tx=shift[0] for BIT_CLK cycles per bit.
    - After each bit, shift right and increment bit index (3 bits).
    - After bit index 7 completes, go to STOP.
  - STOP: tx=1 for BIT_CLK cycles, then go to IDLE.
- Latency: tx falls on the first cycle after the transfer edge.
- Frame length: 10*BIT_CLK cycles with tx driven by the frame.
- busy=1 from START through the last STOP cycle.
- Back-to-back frames:
  - The earliest next transfer is the IDLE cycle after STOP.
  - Minimum line-high gap between frames = BIT_CLK+1 cycles (stop bit plus one IDLE cycle).
- Baud counter:
  - Width $clog2(BIT_CLK); counts 0..BIT_CLK-1.
  - Wraps to 0 on terminal count; the terminal count advances state/bit.
  - It never exceeds BIT_CLK-1.
- tx_valid held high continuously: bytes are taken one per frame, with no loss or duplication.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = ^byte (even parity) for BIT_CLK cycles.
  - Frame = 11*BIT_CLK cycles.
- Undefined: no PARITY state; 8N1 as above.
- The handshake and all other timing are unchanged either way.

Decomposition:
- Package uart_pkg holds:
  - enum tx_state_t {IDLE, START, DATA, PARITY, STOP}; PARITY is unused when the macro is off.
  - Constant DATA_BITS=8.
  - Function bit_clk(clk_hz, bps) returning the integer cycles/bit, shared with the receiver.
- One natural sub-module: uart_baud_gen.
  - Counter with clear input and one-cycle terminal-count pulse.
  - Reusable by the receiver.

Test Plan:
(Use CLK_HZ=1_600_000, BITRATE_BPS=100_000, so BIT_CLK=16.)
- Single byte 0xA5 → after the handshake, tx = 0,1,0,1,0,0,1,0,1,1, each held exactly 16 cycles. busy high for 160 cycles, tx_ready low throughout.
- tx_valid held high with 0x00 then 0xFF → two complete frames, in order. Line high for exactly 17 cycles between the end of the first frame's data and the second start bit.
- rst asserted at cycle 40 of a 0x3C frame → next cycle: tx=1, busy=0, tx_ready=1. Next byte 0x81 is transmitted cleanly.
- tx_valid pulsed while busy (0x55 mid-frame) → not accepted, tx_ready=0; frame in flight unaltered.
- UART_TX_PARITY_EN defined, byte 0x07 → parity bit 1 after data. Frame is 176 cycles; byte 0xA5 gives parity bit 0.
- Loopback into uart_rx with matching parameters → 256 random bytes received identical, one data_valid per byte.
